// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan capture block.
//   SEG_0..SEG_9   : active-low cathode patterns {a,b,c,d,e,f,g} (bit6=a).
//   AN_*           : active-low anode codes for each digit position and blank.
//   filt_state_e   : states of the {AN,CA} glitch filter.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;

  localparam logic [3:0] AN_SEC_ONES = 4'b1110;
  localparam logic [3:0] AN_SEC_TENS = 4'b1101;
  localparam logic [3:0] AN_MIN_ONES = 4'b1011;
  localparam logic [3:0] AN_MIN_TENS = 4'b0111;
  localparam logic [3:0] AN_BLANK    = 4'b1111;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_HELD   = 2'd2
  } filt_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational decode of an active-low cathode pattern
// back to a BCD digit.
//   ca    in  7  cathode pattern, bit6=a .. bit0=g
//   digit out 4  decoded digit, 4'hF when the pattern is not a digit
//   valid out 1  pattern matched one of the ten digit shapes
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] ca,
  output logic [3:0] digit,
  output logic       valid
);

  // Pattern lookup; anything outside the ten shapes is flagged invalid.
  always_comb begin
    digit = 4'hF;
    valid = 1'b1;
    case (ca)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit = 4'hF;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: monitors a multiplexed 4-digit 7-segment bus, filters
// scan glitches, decodes each lit digit and publishes complete MM:SS frames.
//   Clock, reset          : clock and synchronous active-high reset
//   CA[6:0], AN[3:0]      : active-low cathode / anode buses
//   digits[15:0]          : BCD {min tens, min ones, sec tens, sec ones}
//   minutes[6:0]          : binary minutes, seconds[5:0]: binary seconds
//   frame_valid/frame_err : one-cycle frame published / frame rejected
//   seg_err/anode_err     : one-cycle undecodable pattern / multiple anodes
//   scan_lost             : level, no one-hot accept for TIMEOUT_CYCLES
// Build option SEG7_CAP_SYNC_EN inserts a two-flop synchronizer on the
// 11 input bits (adds two cycles to every latency).
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic [6:0]  CA,
  input  logic [3:0]  AN,
  output logic [15:0] digits,
  output logic [6:0]  minutes,
  output logic [5:0]  seconds,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        seg_err,
  output logic        anode_err,
  output logic        scan_lost
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYCLES);

  logic [10:0] pin_s;

`ifdef SEG7_CAP_SYNC_EN
  logic [10:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous display sources.
  always_ff @(posedge Clock) begin
    if (reset) begin
      sync1_q <= {AN_BLANK, 7'h7F};
      sync2_q <= {AN_BLANK, 7'h7F};
    end else begin
      sync1_q <= {AN, CA};
      sync2_q <= sync1_q;
    end
  end
  assign pin_s = sync2_q;
`else
  assign pin_s = {AN, CA};
`endif

  filt_state_e state_q, state_d;
  logic [10:0]   sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    seen_q, seen_d, bad_q, bad_d;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   digits_q, digits_d;
  logic [6:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic          seg_err_q, seg_err_d, anode_err_q, anode_err_d;
  logic          scan_lost_q, scan_lost_d;

  logic [3:0] an_s;
  logic [3:0] dec_digit_s;
  logic       dec_valid_s;
  logic       accept_s;
  logic       onehot_s;
  logic [1:0] pos_s;

  assign an_s = sample_q[10:7];

  seg7_pattern_decode u_decode (
    .ca    (sample_q[6:0]),
    .digit (dec_digit_s),
    .valid (dec_valid_s)
  );

  // Map the sampled anode code to a digit position; non-codes are not one-hot.
  always_comb begin
    pos_s    = 2'd0;
    onehot_s = 1'b0;
    case (an_s)
      AN_SEC_ONES: begin pos_s = 2'd0; onehot_s = 1'b1; end
      AN_SEC_TENS: begin pos_s = 2'd1; onehot_s = 1'b1; end
      AN_MIN_ONES: begin pos_s = 2'd2; onehot_s = 1'b1; end
      AN_MIN_TENS: begin pos_s = 2'd3; onehot_s = 1'b1; end
      default:     begin pos_s = 2'd0; onehot_s = 1'b0; end
    endcase
  end

  // Filter FSM. The incoming value is compared against the sample register,
  // so the count reaches STABLE_CYCLES-1 exactly when STABLE_CYCLES identical
  // samples are held; the ACCEPT cycle then registers its action one edge later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (pin_s == sample_q) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ACCEPT;
          end else begin
            state_d = ST_SETTLE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_ACCEPT: begin
        accept_s = 1'b1;
        cnt_d    = '0;
        // A change arriving during the accept cycle must start a fresh settle.
        if (pin_s == sample_q) begin
          state_d = ST_HELD;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_HELD: begin
        cnt_d = '0;
        if (pin_s != sample_q) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Masks, digit buffer, timeout and frame publication.
  always_comb begin
    sample_d      = pin_s;
    seen_d        = seen_q;
    bad_d         = bad_q;
    buf_d         = buf_q;
    digits_d      = digits_q;
    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    seg_err_d     = 1'b0;
    anode_err_d   = 1'b0;
    scan_lost_d   = scan_lost_q;
    timer_d       = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_ONE;

    if (timer_q == TMR_MAX) begin
      scan_lost_d = 1'b1;
      seen_d      = 4'b0000;
      bad_d       = 4'b0000;
    end else begin
      scan_lost_d = scan_lost_q;
    end

    // Evaluate a completed frame; the masks always restart afterwards.
    if (seen_q == 4'b1111) begin
      seen_d = 4'b0000;
      bad_d  = 4'b0000;
      if ((bad_q == 4'b0000) && (buf_q[7:4] <= 4'd5)) begin
        frame_valid_d = 1'b1;
        digits_d      = buf_q;
        minutes_d     = {3'b000, buf_q[15:12]} * 7'd10 + {3'b000, buf_q[11:8]};
        seconds_d     = {2'b00, buf_q[7:4]} * 6'd10 + {2'b00, buf_q[3:0]};
      end else begin
        frame_err_d = 1'b1;
      end
    end else begin
      frame_err_d = 1'b0;
    end

    // Accept action; blank scans are ignored and do not refresh the timeout.
    if (accept_s) begin
      if (an_s == AN_BLANK) begin
        anode_err_d = 1'b0;
      end else if (onehot_s) begin
        buf_d[{pos_s, 2'b00} +: 4] = dec_digit_s;
        bad_d[pos_s]  = ~dec_valid_s;
        seen_d[pos_s] = 1'b1;
        seg_err_d     = ~dec_valid_s;
        timer_d       = '0;
        scan_lost_d   = 1'b0;
      end else begin
        anode_err_d = 1'b1;
      end
    end else begin
      anode_err_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q       <= ST_SETTLE;
      sample_q      <= {AN_BLANK, 7'h7F};
      cnt_q         <= '0;
      timer_q       <= '0;
      seen_q        <= 4'b0000;
      bad_q         <= 4'b0000;
      buf_q         <= 16'h0000;
      digits_q      <= 16'h0000;
      minutes_q     <= 7'd0;
      seconds_q     <= 6'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
      scan_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      seen_q        <= seen_d;
      bad_q         <= bad_d;
      buf_q         <= buf_d;
      digits_q      <= digits_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      seg_err_q     <= seg_err_d;
      anode_err_q   <= anode_err_d;
      scan_lost_q   <= scan_lost_d;
    end
  end

  assign digits      = digits_q;
  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign seg_err     = seg_err_q;
  assign anode_err   = anode_err_q;
  assign scan_lost   = scan_lost_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: a table of full four-digit scans
// plus hand-written sequences for latency, glitch, anode error, reset and
// timeout behaviour.
module tb_seg7_scan_capture;

  localparam int STABLE = 4;
  localparam int TMO    = 300;

  localparam logic [6:0] T0 = 7'b0000001;
  localparam logic [6:0] T1 = 7'b1001111;
  localparam logic [6:0] T2 = 7'b0010010;
  localparam logic [6:0] T3 = 7'b0000110;
  localparam logic [6:0] T4 = 7'b1001100;
  localparam logic [6:0] T5 = 7'b0100100;
  localparam logic [6:0] T6 = 7'b0100000;
  localparam logic [6:0] T7 = 7'b0001111;
  localparam logic [6:0] T8 = 7'b0000000;
  localparam logic [6:0] T9 = 7'b0001100;
  localparam logic [6:0] TX = 7'b1111111;

  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] AB = 4'b1111;

  logic        Clock = 1'b0;
  logic        reset;
  logic [6:0]  CA;
  logic [3:0]  AN;
  logic [15:0] digits;
  logic [6:0]  minutes;
  logic [5:0]  seconds;
  logic        frame_valid, frame_err, seg_err, anode_err, scan_lost;

  int checks = 0;
  int failures = 0;
  int n_fv = 0, n_fe = 0, n_se = 0, n_ae = 0, n_excl = 0;
  int b_fv, b_fe, b_se, b_ae;

  typedef struct {
    logic [6:0]  ca0, ca1, ca2, ca3;
    logic [15:0] e_dig;
    logic [6:0]  e_min;
    logic [5:0]  e_sec;
    int          e_fv, e_fe, e_se;
  } vec_t;

  vec_t tab [7];

  seg7_scan_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock       (Clock),
    .reset       (reset),
    .CA          (CA),
    .AN          (AN),
    .digits      (digits),
    .minutes     (minutes),
    .seconds     (seconds),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .seg_err     (seg_err),
    .anode_err   (anode_err),
    .scan_lost   (scan_lost)
  );

  always #5 Clock = ~Clock;

  // Pulse counters and exclusivity monitor.
  always @(posedge Clock) begin
    if (frame_valid) n_fv <= n_fv + 1;
    if (frame_err)   n_fe <= n_fe + 1;
    if (seg_err)     n_se <= n_se + 1;
    if (anode_err)   n_ae <= n_ae + 1;
    if ((frame_valid && frame_err) || (seg_err && anode_err)) n_excl <= n_excl + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] ca);
    AN = an;
    CA = ca;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic scan(input logic [6:0] c0, input logic [6:0] c1,
                      input logic [6:0] c2, input logic [6:0] c3);
    drive(A0, c0); tick(20);
    drive(A1, c1); tick(20);
    drive(A2, c2); tick(20);
    drive(A3, c3); tick(20);
    drive(AB, TX); tick(10);
  endtask

  task automatic snap();
    b_fv = n_fv; b_fe = n_fe; b_se = n_se; b_ae = n_ae;
  endtask

  initial begin
    tab[0] = '{T4, T3, T2, T1, 16'h1234, 7'd12, 6'd34, 1, 0, 0};
    tab[1] = '{T9, T5, T9, T5, 16'h5959, 7'd59, 6'd59, 1, 0, 0};
    tab[2] = '{T0, T0, T0, T0, 16'h0000, 7'd0,  6'd0,  1, 0, 0};
    tab[3] = '{T0, T5, T9, T9, 16'h9950, 7'd99, 6'd50, 1, 0, 0};
    tab[4] = '{T4, T3, TX, T1, 16'h9950, 7'd99, 6'd50, 0, 1, 1};
    tab[5] = '{T4, T6, T2, T1, 16'h9950, 7'd99, 6'd50, 0, 1, 0};
    tab[6] = '{T8, T0, T7, T0, 16'h0708, 7'd7,  6'd8,  1, 0, 0};

    reset = 1'b1;
    drive(AB, TX);
    tick(3);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_min", minutes, 7'd0);
    chk("rst_sec", seconds, 6'd0);
    chk("rst_flags", {frame_valid, frame_err, seg_err, anode_err, scan_lost}, 5'b00000);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 7; i++) begin
      snap();
      scan(tab[i].ca0, tab[i].ca1, tab[i].ca2, tab[i].ca3);
      chk($sformatf("v%0d_digits", i), digits, tab[i].e_dig);
      chk($sformatf("v%0d_min", i), minutes, tab[i].e_min);
      chk($sformatf("v%0d_sec", i), seconds, tab[i].e_sec);
      chk($sformatf("v%0d_fv", i), n_fv - b_fv, tab[i].e_fv);
      chk($sformatf("v%0d_fe", i), n_fe - b_fe, tab[i].e_fe);
      chk($sformatf("v%0d_se", i), n_se - b_se, tab[i].e_se);
    end

    // Frame latency: STABLE+2 edges after the last digit appears.
    snap();
    drive(A0, T3); tick(20);
    drive(A1, T4); tick(20);
    drive(A2, T1); tick(20);
    drive(A3, T2);
    tick(STABLE + 1);
    chk("lat_fv_early", frame_valid, 1'b0);
    tick(1);
    chk("lat_fv", frame_valid, 1'b1);
    chk("lat_digits", digits, 16'h2143);
    chk("lat_min", minutes, 7'd21);
    chk("lat_sec", seconds, 6'd43);
    tick(1);
    chk("lat_fv_pulse", frame_valid, 1'b0);
    tick(13);
    drive(AB, TX); tick(10);
    chk("lat_fv_count", n_fv - b_fv, 1);

    // seg_err latency: STABLE+1 edges; then the frame is rejected.
    snap();
    drive(A0, TX);
    tick(STABLE);
    chk("seg_early", seg_err, 1'b0);
    tick(1);
    chk("seg_pulse", seg_err, 1'b1);
    tick(15);
    drive(A1, T0); tick(20);
    drive(A2, T0); tick(20);
    drive(A3, T0); tick(20);
    drive(AB, TX); tick(10);
    chk("seg_fe", n_fe - b_fe, 1);
    chk("seg_se", n_se - b_se, 1);
    chk("seg_fv", n_fv - b_fv, 0);
    chk("seg_hold", digits, 16'h2143);

    // Glitch held only STABLE-1 samples is never accepted.
    snap();
    drive(A0, T4); tick(20);
    drive(A1, T9); tick(STABLE - 1);
    drive(A1, T3); tick(20);
    drive(A2, T2); tick(20);
    drive(A3, T1); tick(20);
    drive(AB, TX); tick(10);
    chk("gl_digits", digits, 16'h1234);
    chk("gl_fv", n_fv - b_fv, 1);
    chk("gl_se", n_se - b_se, 0);

    // Multiple anodes low: one anode_err pulse, seen mask untouched.
    snap();
    drive(A0, T8); tick(20);
    drive(A1, T5); tick(20);
    drive(A2, T6); tick(20);
    drive(4'b1100, T1); tick(10);
    chk("an_ae", n_ae - b_ae, 1);
    chk("an_nofv", n_fv - b_fv, 0);
    chk("an_nofe", n_fe - b_fe, 0);
    drive(A3, T3); tick(20);
    drive(AB, TX); tick(10);
    chk("an_digits", digits, 16'h3658);
    chk("an_min", minutes, 7'd36);
    chk("an_sec", seconds, 6'd58);
    chk("an_fv", n_fv - b_fv, 1);

    // Reset mid-frame discards the partial frame.
    drive(A0, T7); tick(20);
    drive(A1, T1); tick(20);
    drive(AB, TX);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("mr_digits", digits, 16'h0000);
    chk("mr_min", minutes, 7'd0);
    snap();
    drive(A2, T2); tick(20);
    drive(A3, T0); tick(20);
    drive(AB, TX); tick(10);
    chk("mr_nofv", n_fv - b_fv, 0);
    chk("mr_nofe", n_fe - b_fe, 0);
    snap();
    scan(T7, T1, T2, T0);
    chk("mr_fv", n_fv - b_fv, 1);
    chk("mr_full", digits, 16'h0217);
    chk("mr_sec", seconds, 6'd17);

    // Timeout: scan_lost sets, masks clear, next one-hot accept clears it.
    snap();
    tick(150);
    chk("to_not_yet", scan_lost, 1'b0);
    tick(200);
    chk("to_lost", scan_lost, 1'b1);
    drive(A0, T1);
    tick(STABLE);
    chk("to_lost_hold", scan_lost, 1'b1);
    tick(1);
    chk("to_cleared", scan_lost, 1'b0);
    tick(15);
    drive(A1, T2); tick(20);
    drive(AB, TX); tick(10);
    chk("to_mask_fv", n_fv - b_fv, 0);
    chk("to_mask_fe", n_fe - b_fe, 0);
    chk("to_digits", digits, 16'h0217);

    chk("exclusive", n_excl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
